jk_bank_driver: RTL and testbench
=================================

Name: jk_bank_driver

Overview:
Command-side driver for a bank of WIDTH gate-level J-K master-slave flip-flops with active-low asynchronous Set/Rst inputs. It accepts load, toggle, clear and preset commands over a Req/Ready handshake. It generates the J/K excitation, a single bank clock strobe, and active-low Set/Rst pulses, then reads Q back to confirm the result. It sits between a register-file controller and the flop bank.

Parameters:
WIDTH, 8, number of flops in the bank
PULSE_CYC, 2, cycles the Set_n/Rst_n pulse stays low for clear/preset (must be >= 1)
MAX_RETRY, 3, readback retries before Err (used only with JK_VERIFY_EN)

Ports:
Clk  input  1  system clock, rising edge
Rst  input  1  asynchronous, active-high reset
Req  input  1  command request
Cmd  input  2  00 load, 01 toggle, 10 clear, 11 preset
Data  input  WIDTH  load value (Cmd 00) or toggle mask (Cmd 01); ignored otherwise
Ready  output  1  high in IDLE; a command is accepted on Req&&Ready
Done  output  1  one-cycle completion pulse
Err  output  1  one-cycle pulse coincident with Done on verify failure
J  output  WIDTH  J inputs to bank
K  output  WIDTH  K inputs to bank
Bclk  output  1  bank clock strobe
Set_n  output  1  bank asynchronous set, active low
Rst_n  output  1  bank asynchronous reset, active low
Qin  input  WIDTH  bank Q readback

Behaviour:
- Reset (async, Rst=1): state IDLE, Ready=1, Done=0, Err=0, J=K=0, Bclk=0, Set_n=Rst_n=1, retry count 0. Bank contents are not guaranteed.
- Idle drive, in every state except where stated: J=K=0 (hold), Bclk=0, Set_n=Rst_n=1. All outputs are registered.
- Accept edge: Cmd and Data are captured. The expected value E is computed at the same edge: load E=Data; toggle E=Qin^Data; clear E=0; preset E=all ones. Req is ignored while Ready=0. Data need not be held after acceptance.
- Load/toggle path: IDLE -> SETUP -> STRB_HI -> STRB_LO -> CHECK -> IDLE.
  - SETUP: J/K driven. Load: J=Data, K=~Data. Toggle: J=K=Data.
  - STRB_HI: Bclk=1, J/K held. The master captures.
  - STRB_LO: Bclk=0, J/K held. The slave transfers.
  - CHECK: J=K=0. Compare Qin against E.
- Clear/preset path: IDLE -> PULSE (Rst_n=0 for clear, Set_n=0 for preset, for PULSE_CYC cycles, Bclk=0) -> CHECK -> IDLE.
- Set_n and Rst_n are never low in the same cycle.
- Done timing: Done pulses in the first IDLE cycle after CHECK. For load/toggle, Done is high in the 5th cycle after the accept edge; for clear/preset, in cycle PULSE_CYC+3. Ready rises in the same cycle as Done.
- A new Req in the Done cycle is accepted (back-to-back); there is no idle bubble.
- Mismatch in CHECK with retry < MAX_RETRY: retry++ and go to SETUP as a load of E. Toggle and clear/preset retries therefore become deterministic loads, and a toggle is never re-applied.
- Mismatch with retry == MAX_RETRY: Done=1 and Err=1. Retry count clears on every accept.
- Rst mid-operation: all outputs return to reset values immediately, and no Done is produced. The aborted command is lost.
- Cmd values are fully decoded; there is no illegal encoding.

Optional Feature:
JK_VERIFY_EN
- Defined: CHECK state, retry counter and Err are present, as described above.
- Undefined: CHECK is skipped. STRB_LO or the final PULSE cycle goes straight to IDLE with Done one cycle earlier (load Done at cycle 4, clear at PULSE_CYC+2). Err is tied 0, and Qin is used only to form toggle E, which then has no other use and may be removed.

Decomposition:
- Package jk_pkg: cmd_t enum (CMD_LOAD, CMD_TOGGLE, CMD_CLEAR, CMD_PRESET), state_t enum (IDLE, SETUP, STRB_HI, STRB_LO, PULSE, CHECK), retry counter width localparam $clog2(MAX_RETRY+1).
- Sub-module jk_excite: combinational; takes Cmd and Data and returns the J/K vectors. It is reused by the retry path with Cmd forced to load.

Test Plan:
- Load 8'hA5 after reset, with the bank model responding correctly -> J=8'hA5, K=8'h5A in SETUP; Bclk high exactly one cycle; Done at cycle 5; Err=0; Qin=8'hA5.
- Toggle mask 8'h0F with the bank at 8'hA5 -> J=K=8'h0F; E=8'hAA; Done with Err=0.
- Clear, PULSE_CYC=2 -> Rst_n low exactly 2 cycles; Set_n stays 1; Done at cycle 5; Qin=0.
- Bank model with bit 3 stuck at 0, load 8'hFF -> 3 retries, each driving J=8'hFF; Done and Err high on the same cycle; Ready returns to 1.
- Req held high continuously with alternating load/preset -> back-to-back acceptance at every Done cycle; Set_n and Rst_n are never low together.
- Rst asserted during STRB_HI -> Bclk, J and K drop to 0 immediately; no Done; Ready=1 after release.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared types and helpers for the J-K flop bank command driver.
package jk_pkg;

   typedef enum logic [1:0] {
      CMD_LOAD   = 2'b00,
      CMD_TOGGLE = 2'b01,
      CMD_CLEAR  = 2'b10,
      CMD_PRESET = 2'b11
   } cmd_t;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STRB_HI,
      STRB_LO,
      PULSE,
      CHECK
   } state_t;

   localparam int MAX_RETRY_DEF = 3;

   function automatic int retry_w(input int max_retry);
      return (max_retry < 1) ? 1 : $clog2(max_retry + 1);
   endfunction

endpackage

// File: rtl/jk_bank_driver_excite.sv
// J/K excitation for the flop bank: load drives J=D/K=~D, toggle drives J=K=mask.
module jk_excite
   import jk_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  cmd_t             i_cmd,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_j,
   output logic [WIDTH-1:0] o_k
);

   always_comb begin
      o_j = '0;
      o_k = '0;
      unique case (i_cmd)
         CMD_LOAD: begin
            o_j = i_data;
            o_k = ~i_data;
         end
         CMD_TOGGLE: begin
            o_j = i_data;
            o_k = i_data;
         end
         default: begin
            o_j = '0;
            o_k = '0;
         end
      endcase
   end

endmodule

// File: rtl/jk_bank_driver.sv
// Command driver for a bank of J-K master-slave flops with async Set_n/Rst_n.
// Optional readback verify with retries: define JK_VERIFY_EN.
module jk_bank_driver
   import jk_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int PULSE_CYC = 2,
   parameter int MAX_RETRY = MAX_RETRY_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_req,
   input  logic [1:0]       i_cmd,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_ready,
   output logic             o_done,
   output logic             o_err,
   output logic [WIDTH-1:0] o_j,
   output logic [WIDTH-1:0] o_k,
   output logic             o_bclk,
   output logic             o_set_n,
   output logic             o_rst_n,
   input  logic [WIDTH-1:0] i_qin
);

   localparam int PW = $clog2(PULSE_CYC + 2);
   localparam int RW = retry_w(MAX_RETRY);
   localparam logic [PW-1:0] PC = PW'(PULSE_CYC);

   state_t           r_state, w_nst;
   cmd_t             r_cmd, w_cmd_n;
   logic [WIDTH-1:0] r_data, w_data_n;
   logic [PW-1:0]    r_pcnt, w_pcnt_n;
   logic             w_done_n, w_err_n;
   logic             w_drive, w_low;
   logic [WIDTH-1:0] w_ex_j, w_ex_k;

   logic [WIDTH-1:0] r_j, r_k;
   logic             r_ready, r_done, r_err;
   logic             r_bclk, r_set_n, r_rst_n;

`ifdef JK_VERIFY_EN
   localparam logic [RW-1:0] MR = RW'(MAX_RETRY);
   logic [WIDTH-1:0] r_exp, w_exp_n;
   logic [RW-1:0]    r_retry, w_retry_n;
`else
   logic w_unused;
   assign w_unused = ^{i_qin, RW[0]};
`endif

   jk_excite #(.WIDTH(WIDTH)) u_excite (
      .i_cmd  (w_cmd_n),
      .i_data (w_data_n),
      .o_j    (w_ex_j),
      .o_k    (w_ex_k)
   );

   always_comb begin
      w_nst    = r_state;
      w_cmd_n  = r_cmd;
      w_data_n = r_data;
      w_pcnt_n = r_pcnt;
      w_done_n = 1'b0;
      w_err_n  = 1'b0;
`ifdef JK_VERIFY_EN
      w_exp_n   = r_exp;
      w_retry_n = r_retry;
`endif
      unique case (r_state)
         IDLE: begin
            if (i_req) begin
               w_cmd_n  = cmd_t'(i_cmd);
               w_data_n = i_data;
               w_pcnt_n = '0;
`ifdef JK_VERIFY_EN
               w_retry_n = '0;
               unique case (cmd_t'(i_cmd))
                  CMD_LOAD:   w_exp_n = i_data;
                  CMD_TOGGLE: w_exp_n = i_qin ^ i_data;
                  CMD_CLEAR:  w_exp_n = '0;
                  CMD_PRESET: w_exp_n = '1;
                  default:    w_exp_n = i_data;
               endcase
`endif
               if (i_cmd[1]) w_nst = PULSE;
               else          w_nst = SETUP;
            end
         end
         SETUP:   w_nst = STRB_HI;
         STRB_HI: w_nst = STRB_LO;
         STRB_LO: begin
`ifdef JK_VERIFY_EN
            w_nst = CHECK;
`else
            w_nst    = IDLE;
            w_done_n = 1'b1;
`endif
         end
         PULSE: begin
            // trailing cycle with the pulse released lets the bank settle
            if (r_pcnt == PC) begin
`ifdef JK_VERIFY_EN
               w_nst = CHECK;
`else
               w_nst    = IDLE;
               w_done_n = 1'b1;
`endif
            end else begin
               w_pcnt_n = r_pcnt + 1'b1;
            end
         end
         CHECK: begin
`ifdef JK_VERIFY_EN
            if (i_qin == r_exp) begin
               w_nst    = IDLE;
               w_done_n = 1'b1;
            end else if (r_retry < MR) begin
               w_retry_n = r_retry + 1'b1;
               w_cmd_n   = CMD_LOAD;
               w_data_n  = r_exp;
               w_nst     = SETUP;
            end else begin
               w_nst    = IDLE;
               w_done_n = 1'b1;
               w_err_n  = 1'b1;
            end
`else
            w_nst    = IDLE;
            w_done_n = 1'b1;
`endif
         end
         default: w_nst = IDLE;
      endcase
      w_drive = (w_nst == SETUP) || (w_nst == STRB_HI) ||
                (w_nst == STRB_LO);
      w_low   = (w_nst == PULSE) && (w_pcnt_n < PC);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_cmd   <= CMD_LOAD;
         r_data  <= '0;
         r_pcnt  <= '0;
         r_ready <= 1'b1;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_j     <= '0;
         r_k     <= '0;
         r_bclk  <= 1'b0;
         r_set_n <= 1'b1;
         r_rst_n <= 1'b1;
      end else begin
         r_state <= w_nst;
         r_cmd   <= w_cmd_n;
         r_data  <= w_data_n;
         r_pcnt  <= w_pcnt_n;
         r_ready <= (w_nst == IDLE);
         r_done  <= w_done_n;
         r_err   <= w_err_n;
         r_j     <= w_drive ? w_ex_j : '0;
         r_k     <= w_drive ? w_ex_k : '0;
         r_bclk  <= (w_nst == STRB_HI);
         r_set_n <= !(w_low && (w_cmd_n == CMD_PRESET));
         r_rst_n <= !(w_low && (w_cmd_n == CMD_CLEAR));
      end
   end

`ifdef JK_VERIFY_EN
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_exp   <= '0;
         r_retry <= '0;
      end else begin
         r_exp   <= w_exp_n;
         r_retry <= w_retry_n;
      end
   end
`endif

   assign o_ready = r_ready;
   assign o_done  = r_done;
   assign o_err   = r_err;
   assign o_j     = r_j;
   assign o_k     = r_k;
   assign o_bclk  = r_bclk;
   assign o_set_n = r_set_n;
   assign o_rst_n = r_rst_n;

endmodule

// File: tb/tb_jk_bank_driver.sv
// Directed bench for jk_bank_driver with a behavioural J-K bank model.
module tb_jk_bank_driver;

`ifdef JK_VERIFY_EN
   localparam int LAT        = 5;
   localparam int STUCK_LAT  = 17;
   localparam int STUCK_ERR  = 1;
   localparam int STUCK_STRB = 4;
`else
   localparam int LAT        = 4;
   localparam int STUCK_LAT  = 4;
   localparam int STUCK_ERR  = 0;
   localparam int STUCK_STRB = 1;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req = 1'b0;
   logic [1:0] cmd = 2'b00;
   logic [7:0] data = 8'h00;
   logic       ready, done, err, bclk, set_n, rst_n;
   logic [7:0] j, k;
   logic [7:0] bq = 8'h00;
   logic [7:0] bm = 8'h00;
   logic [7:0] stuck = 8'h00;
   wire  [7:0] qin = bq & ~stuck;

   int checks = 0;
   int errors = 0;
   int both_low = 0;
   int lat_n, strb_n, rstl_n, setl_n, jdiff_n;
   logic [7:0] j1, k1;
   logic       rdy1, err_d;

   jk_bank_driver #(.WIDTH(8), .PULSE_CYC(2), .MAX_RETRY(3)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_req   (req),
      .i_cmd   (cmd),
      .i_data  (data),
      .o_ready (ready),
      .o_done  (done),
      .o_err   (err),
      .o_j     (j),
      .o_k     (k),
      .o_bclk  (bclk),
      .o_set_n (set_n),
      .o_rst_n (rst_n),
      .i_qin   (qin)
   );

   always #5 clk = ~clk;

   // master captures on strobe rise, slave transfers on fall
   always @(posedge bclk) begin
      for (int i = 0; i < 8; i++) begin
         case ({j[i], k[i]})
            2'b01:   bm[i] = 1'b0;
            2'b10:   bm[i] = 1'b1;
            2'b11:   bm[i] = ~bq[i];
            default: bm[i] = bq[i];
         endcase
      end
   end
   always @(negedge bclk) if (set_n === 1'b1 && rst_n === 1'b1) bq = bm;
   always @(negedge rst_n) bq = 8'h00;
   always @(negedge set_n) bq = 8'hFF;

   always @(negedge clk) if (set_n === 1'b0 && rst_n === 1'b0) both_low++;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // called at a negedge; returns at the negedge of the Done cycle
   task automatic run(input logic [1:0] c, input logic [7:0] d,
                      input bit keep);
      req  = 1'b1;
      cmd  = c;
      data = d;
      strb_n = 0; rstl_n = 0; setl_n = 0; jdiff_n = 0;
      lat_n = 0;
      @(posedge clk);
      #1;
      if (!keep) req = 1'b0;
      for (int n = 1; n <= 60; n++) begin
         @(negedge clk);
         if (n == 1) begin
            j1 = j; k1 = k; rdy1 = ready;
         end
         if (bclk) begin
            strb_n++;
            if (j !== j1) jdiff_n++;
         end
         if (!rst_n) rstl_n++;
         if (!set_n) setl_n++;
         if (done) begin
            lat_n = n;
            err_d = err;
            break;
         end
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_ctl", {ready, done, err, bclk, set_n, rst_n}, 6'b100011);
      chk("reset_jk", {j, k}, 16'h0000);
      rst = 1'b0;
      @(negedge clk);

      run(2'b00, 8'hA5, 1'b0);
      chk("load_lat", lat_n, LAT);
      chk("load_j", j1, 8'hA5);
      chk("load_k", k1, 8'h5A);
      chk("load_strb", strb_n, 1);
      chk("load_err", err_d, 1'b0);
      chk("load_ready", ready, 1'b1);
      chk("load_q", qin, 8'hA5);

      run(2'b01, 8'h0F, 1'b0);
      chk("tog_lat", lat_n, LAT);
      chk("tog_jk", {j1, k1}, 16'h0F0F);
      chk("tog_err", err_d, 1'b0);
      chk("tog_q", qin, 8'hAA);

      run(2'b10, 8'h77, 1'b0);
      chk("clr_lat", lat_n, LAT);
      chk("clr_rstl", rstl_n, 2);
      chk("clr_setl", setl_n, 0);
      chk("clr_strb", strb_n, 0);
      chk("clr_q", qin, 8'h00);

      run(2'b11, 8'h00, 1'b0);
      chk("pre_lat", lat_n, LAT);
      chk("pre_setl", setl_n, 2);
      chk("pre_rstl", rstl_n, 0);
      chk("pre_q", qin, 8'hFF);

      run(2'b10, 8'h00, 1'b0);
      stuck = 8'h08;
      run(2'b00, 8'hFF, 1'b0);
      chk("stk_lat", lat_n, STUCK_LAT);
      chk("stk_err", err_d, STUCK_ERR[0]);
      chk("stk_strb", strb_n, STUCK_STRB);
      chk("stk_j", j1, 8'hFF);
      chk("stk_jdiff", jdiff_n, 0);
      chk("stk_ready", ready, 1'b1);
      chk("stk_q", qin, 8'hF7);
      @(negedge clk);
      chk("stk_err_pulse", {done, err}, 2'b00);
      stuck = 8'h00;

      run(2'b00, 8'h3C, 1'b1);
      chk("b2b0_lat", lat_n, LAT);
      chk("b2b0_q", qin, 8'h3C);
      run(2'b11, 8'h00, 1'b1);
      chk("b2b1_lat", lat_n, LAT);
      chk("b2b1_acc", rdy1, 1'b0);
      chk("b2b1_q", qin, 8'hFF);
      run(2'b00, 8'hC3, 1'b1);
      chk("b2b2_lat", lat_n, LAT);
      chk("b2b2_acc", rdy1, 1'b0);
      chk("b2b2_q", qin, 8'hC3);
      run(2'b11, 8'h00, 1'b1);
      chk("b2b3_lat", lat_n, LAT);
      chk("b2b3_acc", rdy1, 1'b0);
      chk("b2b3_q", qin, 8'hFF);
      req = 1'b0;
      @(negedge clk);
      chk("both_low", both_low, 0);

      req = 1'b1; cmd = 2'b00; data = 8'h55;
      @(posedge clk);
      #1 req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("abort_pre_bclk", bclk, 1'b1);
      rst = 1'b1;
      #1;
      chk("abort_bclk", bclk, 1'b0);
      chk("abort_jk", {j, k}, 16'h0000);
      chk("abort_ready", ready, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      lat_n = 0;
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         if (done) lat_n++;
      end
      chk("abort_nodone", lat_n, 0);
      chk("abort_idle", {ready, bclk, set_n, rst_n}, 4'b1011);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
